stack_unit: RTL and testbench

STACK_UNIT -- requirements
Module: stack_unit

---
 rtl/stack_pkg.sv | 37 +++
 rtl/stack_ram.sv | 32 +++
 rtl/stack_unit.sv | 166 ++++++++++++++++
 tb/tb_stack_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// stack_pkg: shared definitions for the stack unit.
//   stack_op_e    - 3-bit operation code carried on stackOP
//   MIN_*         - fewest valid entries each operation needs
//   MAX_HEADROOM  - free entries PUSH/DUP need (legal while count <= DEPTH-1)
//   min_operands  - operand minimum for any opcode (0 when there is none)
package stack_pkg;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_PUSH    = 3'd1,
        OP_POP     = 3'd2,
        OP_REPLACE = 3'd3,
        OP_POPREP  = 3'd4,
        OP_SWAP    = 3'd5,
        OP_DUP     = 3'd6,
        OP_CLEAR   = 3'd7
    } stack_op_e;

    localparam int unsigned MIN_REPLACE  = 1;
    localparam int unsigned MIN_POP      = 1;
    localparam int unsigned MIN_DUP      = 1;
    localparam int unsigned MIN_POPREP   = 2;
    localparam int unsigned MIN_SWAP     = 2;
    localparam int unsigned MAX_HEADROOM = 1;

    function automatic int unsigned min_operands(input stack_op_e op);
        case (op)
            OP_REPLACE: return MIN_REPLACE;
            OP_POP:     return MIN_POP;
            OP_DUP:     return MIN_DUP;
            OP_POPREP:  return MIN_POPREP;
            OP_SWAP:    return MIN_SWAP;
            default:    return 0;
        endcase
    endfunction

endpackage

// File: rtl/stack_ram.sv
// stack_ram: spill storage for the stack entries below the top two.
// One synchronous write port, one asynchronous read port, no reset.
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data (combinational from raddr)
module stack_ram #(
    parameter int WIDTH   = 16,
    parameter int ENTRIES = 14,
    parameter int AW      = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [ENTRIES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// stack_unit: hardware stack with the two top entries in registers (a, b)
// and the remaining DEPTH-2 entries in a circular spill array.
//   CLK     - clock, all state changes on the rising edge
//   reset   - asynchronous active-high reset
//   stackOP - operation (see stack_pkg::stack_op_e)
//   w       - write data for PUSH, REPLACE, POPREP
//   a, b    - top and second entry, registered
//   count   - number of valid entries, 0..DEPTH
//   empty   - count == 0
//   full    - count == DEPTH
//   err     - sticky overflow/underflow flag
// Build option STACK_GUARD_EN: illegal operations are suppressed and set
// err (cleared by reset or CLEAR). Without it, err is 0, overflow
// overwrites the oldest spilled entry and count saturates at both ends.
module stack_unit
    import stack_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic [2:0]               stackOP,
    input  logic [WIDTH-1:0]         w,
    output logic [WIDTH-1:0]         a,
    output logic [WIDTH-1:0]         b,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     err
);

    localparam int N  = DEPTH - 2;
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    stack_op_e        op;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    ptr_inc;
    logic [PW-1:0]    ptr_dec;
    logic             has_b;
    logic             has_spill;
    logic             at_max;
    logic             do_op;
    logic             ram_we;
    logic [WIDTH-1:0] ram_rdata;
    logic [WIDTH-1:0] refill;

    assign op = stack_op_e'(stackOP);

    // ptr is the next free slot; the top spilled entry sits at ptr-1.
    // DEPTH-2 is generally not a power of two, so wrap explicitly.
    assign ptr_inc = (ptr == PW'(N - 1)) ? '0 : ptr + PW'(1);
    assign ptr_dec = (ptr == '0) ? PW'(N - 1) : ptr - PW'(1);

    assign has_b     = (count >= CW'(2));
    assign has_spill = (count >  CW'(2));
    assign at_max    = (count == CW'(DEPTH));

    // A register vacated with nothing left in the array loads zero.
    assign refill = has_spill ? ram_rdata : '0;

`ifdef STACK_GUARD_EN
    logic legal;

    always_comb begin
        legal = 1'b1;
        if (count < CW'(min_operands(op))) begin
            legal = 1'b0;
        end
        if ((op == OP_PUSH || op == OP_DUP) &&
            (count > CW'(DEPTH - int'(MAX_HEADROOM)))) begin
            legal = 1'b0;
        end
    end

    assign do_op = legal;
`else
    assign do_op = 1'b1;
    assign err   = 1'b0;
`endif

    // Old b only spills when it is a real entry. When the array is full
    // the write at ptr lands on the oldest entry, which is the intended
    // overwrite in the unguarded build. Writes are blocked during reset so
    // an interrupted operation leaves no trace.
    assign ram_we = !reset && do_op && has_b && (op == OP_PUSH || op == OP_DUP);

    stack_ram #(
        .WIDTH   (WIDTH),
        .ENTRIES (N),
        .AW      (PW)
    ) u_ram (
        .clk   (CLK),
        .we    (ram_we),
        .waddr (ptr),
        .wdata (b),
        .raddr (ptr_dec),
        .rdata (ram_rdata)
    );

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            a     <= '0;
            b     <= '0;
            count <= '0;
            ptr   <= '0;
        end else if (do_op) begin
            case (op)
                OP_PUSH: begin
                    a <= w;
                    b <= a;
                    if (has_b)   ptr   <= ptr_inc;
                    if (!at_max) count <= count + CW'(1);
                end
                OP_POP: begin
                    a <= b;
                    b <= refill;
                    if (has_spill)      ptr   <= ptr_dec;
                    if (count != '0)    count <= count - CW'(1);
                end
                OP_REPLACE: begin
                    a <= w;
                end
                OP_POPREP: begin
                    a <= w;
                    b <= refill;
                    if (has_spill)      ptr   <= ptr_dec;
                    if (count != '0)    count <= count - CW'(1);
                end
                OP_SWAP: begin
                    a <= b;
                    b <= a;
                end
                OP_DUP: begin
                    b <= a;
                    if (has_b)   ptr   <= ptr_inc;
                    if (!at_max) count <= count + CW'(1);
                end
                OP_CLEAR: begin
                    a     <= '0;
                    b     <= '0;
                    count <= '0;
                    ptr   <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef STACK_GUARD_EN
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (!legal) begin
            err <= 1'b1;
        end else if (op == OP_CLEAR) begin
            err <= 1'b0;
        end
    end
`endif

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: tb/tb_stack_unit.sv
module tb_stack_unit;
    import stack_pkg::*;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;

    logic                   CLK;
    logic                   reset;
    logic [2:0]             stackOP;
    logic [WIDTH-1:0]       w;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic [$clog2(DEPTH):0] count;
    logic                   empty;
    logic                   full;
    logic                   err;

    int checks   = 0;
    int failures = 0;

    stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK     (CLK),
        .reset   (reset),
        .stackOP (stackOP),
        .w       (w),
        .a       (a),
        .b       (b),
        .count   (count),
        .empty   (empty),
        .full    (full),
        .err     (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one op across a rising edge; leaves the bus at NOP, 1 time unit after the edge.
    task automatic step(input logic [2:0] op, input logic [WIDTH-1:0] data);
        stackOP = op;
        w       = data;
        @(posedge CLK);
        #1;
        stackOP = OP_NOP;
        w       = '0;
    endtask

    task automatic state(input string tag, input logic [15:0] ea, input logic [15:0] eb,
                         input logic [31:0] ec);
        chk({tag, "_a"}, 32'(a), 32'(ea));
        chk({tag, "_b"}, 32'(b), 32'(eb));
        chk({tag, "_count"}, 32'(count), ec);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset   = 1'b1;
        stackOP = OP_NOP;
        w       = '0;
        repeat (2) @(posedge CLK);
        #1;
        reset = 1'b0;

        // reset state
        state("reset", 16'h0, 16'h0, 0);
        chk("reset_empty", 32'(empty), 1);
        chk("reset_full", 32'(full), 0);
        chk("reset_err", 32'(err), 0);

        // basic pushes
        step(OP_PUSH, 16'h0001);
        step(OP_PUSH, 16'h0002);
        step(OP_PUSH, 16'h0003);
        state("push3", 16'h0003, 16'h0002, 3);

        step(OP_POPREP, 16'h0005);
        state("poprep", 16'h0005, 16'h0001, 2);
        step(OP_SWAP, 16'h0000);
        state("swap", 16'h0001, 16'h0005, 2);
        step(OP_REPLACE, 16'h0007);
        state("replace", 16'h0007, 16'h0005, 2);
        step(OP_DUP, 16'h0000);
        state("dup", 16'h0007, 16'h0007, 3);
        step(OP_NOP, 16'hBEEF);
        state("nop", 16'h0007, 16'h0007, 3);
        step(OP_POP, 16'h0000);
        state("pop_after_dup", 16'h0007, 16'h0005, 2);
        step(OP_CLEAR, 16'h0000);
        state("clear", 16'h0, 16'h0, 0);
        chk("clear_empty", 32'(empty), 1);

        // fill to capacity
        for (int i = 0; i < DEPTH; i++) step(OP_PUSH, 16'(16'h0010 + i));
        state("fill", 16'h001F, 16'h001E, DEPTH);
        chk("fill_full", 32'(full), 1);
        chk("fill_empty", 32'(empty), 0);

        // drain, top must descend through every pushed value
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("drain_a%0d", i), 32'(a), 32'(16'h001F - i));
            step(OP_POP, 16'h0000);
        end
        state("drained", 16'h0, 16'h0, 0);
        chk("drained_empty", 32'(empty), 1);

        // underflow on empty stack
        step(OP_POP, 16'h0000);
        state("underflow", 16'h0, 16'h0, 0);
`ifdef STACK_GUARD_EN
        chk("underflow_err", 32'(err), 1);
        step(OP_CLEAR, 16'h0000);
        chk("underflow_clear_err", 32'(err), 0);
`else
        chk("underflow_err", 32'(err), 0);
`endif

        // refill, then overflow
        for (int i = 0; i < DEPTH; i++) step(OP_PUSH, 16'(16'h0010 + i));
        step(OP_PUSH, 16'hFFFF);
`ifdef STACK_GUARD_EN
        state("ovf_guard", 16'h001F, 16'h001E, DEPTH);
        chk("ovf_guard_err", 32'(err), 1);
        step(OP_CLEAR, 16'h0000);
        chk("ovf_clear_err", 32'(err), 0);
        chk("ovf_clear_count", 32'(count), 0);
`else
        state("ovf", 16'hFFFF, 16'h001F, DEPTH);
        chk("ovf_err", 32'(err), 0);
        // oldest entry (0x0010) was overwritten by the spilled 0x001E
        chk("ovf_drain_a0", 32'(a), 32'hFFFF);
        step(OP_POP, 16'h0000);
        for (int i = 0; i < DEPTH - 1; i++) begin
            chk($sformatf("ovf_drain_a%0d", i + 1), 32'(a), 32'(16'h001F - i));
            step(OP_POP, 16'h0000);
        end
        state("ovf_drained", 16'h0, 16'h0, 0);
`endif

        // reset between edges during a PUSH
        step(OP_PUSH, 16'h0033);
        chk("pre_rst_count", 32'(count), 1);
        stackOP = OP_PUSH;
        w       = 16'h0099;
        #2;
        reset = 1'b1;
        #1;
        state("async_rst", 16'h0, 16'h0, 0);
        chk("async_rst_err", 32'(err), 0);
        #1;
        reset   = 1'b0;
        stackOP = OP_NOP;
        step(OP_PUSH, 16'h0042);
        state("post_rst", 16'h0042, 16'h0000, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
